weight_load_ctl: RTL and testbench
==================================

# weight_load_ctl

Loads one layer's weight set from an upstream valid/ready stream into the weight buffer. Writes linear addresses in the layout the read-address controller consumes: `wdepth = (k*CIG*COALIGN + cig*COALIGN + co)/CH_OUT`. Asserts `O_weight_load_done` once the last word is written, which gates the start of buffer reads. Sits directly upstream of the read-address controller, sharing its `I_ap_start`, geometry inputs and the weight BRAM.

## Interface
- `AXIWIDTH`, 32: width of geometry inputs.
- `DEPTHWIDTH`, 9: weight buffer address width; capacity is 2**DEPTHWIDTH words.
- `CH_OUT`, 32: output channels per buffer word; must be a power of 2.
- `WWIDTH`, 256: weight buffer word width (CH_OUT × 8 bit).
- `I_clk` in 1: clock.
- `I_rst` in 1: asynchronous, active-low reset.
- `I_ap_start` in 1: layer start; a rising edge starts or restarts a load.
- `I_kx_num` in AXIWIDTH: kernel width.
- `I_ky_num` in AXIWIDTH: kernel height.
- `I_ciGroup` in DEPTHWIDTH: input-channel groups (CIG).
- `I_coAlign` in DEPTHWIDTH+1: output channels aligned to CH_OUT.
- `I_wdata` in WWIDTH: weight word.
- `I_wdata_valid` in 1: `I_wdata` valid.
- `O_wdata_ready` out 1: block accepts a word.
- `O_wbuf_wr_en` out 1: buffer write strobe.
- `O_wbuf_waddr` out DEPTHWIDTH: buffer write address.
- `O_wbuf_wdata` out WWIDTH: buffer write data.
- `O_weight_load_done` out 1: level; all words written.
- `O_cfg_err` out 1: level; word count is 0 or exceeds capacity.

## Operation
- Start detect: 2-bit shift register `s_start <= {s_start[0], I_ap_start}`. Start pulse = `s_start[0] & ~s_start[1]`.
- FSM states: IDLE, CALC0, CALC1, LOAD, DONE.
  - Start pulse in any state → CALC0. Clears `O_weight_load_done`, `O_cfg_err`, address counter and word count.
  - CALC0 registers `p0 = I_kx_num*I_ky_num` and `cw = I_coAlign >> log2(CH_OUT)`.
  - CALC1 registers `N = p0*I_ciGroup*cw` at 32-bit width.
  - N==0 or N > 2**DEPTHWIDTH → DONE with `O_cfg_err=1`, done=1, no writes.
  - Otherwise → LOAD.
  - LOAD: `O_wdata_ready=1`. On each handshake (valid & ready): write word at address `wcnt`, then increment `wcnt`. When the accepted word has index N-1 → DONE.
  - DONE: ready=0, done=1. Holds until the next start pulse.
- Write port is registered. An accept in cycle t gives `O_wbuf_wr_en=1`, addr=`wcnt`, data=`I_wdata` in cycle t+1. Otherwise `wr_en=0`; addr/data hold.
- Words presented while ready=0 are not consumed. The upstream source holds them.
- Geometry inputs are sampled only in CALC0/CALC1. Changes during LOAD have no effect.
- `wcnt` never wraps. The capacity check guarantees at most 2**DEPTHWIDTH writes.

## Timing
- Reset (`I_rst`=0, async): state IDLE, `s_start`=0, all outputs 0, counters 0.
- Start edge on `I_ap_start` sampled at clock c: pulse at c+1, CALC0 at c+2, CALC1 at c+3, LOAD (ready=1) at c+4.
- Throughput: one word per cycle while valid stays high.
- Last accept at cycle t: last write at t+1; `O_weight_load_done`=1 and ready=0 from t+1.
- Done therefore never rises before the last write strobe.
- Start pulse during LOAD aborts the load:
  - ready drops next cycle.
  - A write already registered from the previous cycle still completes.
  - The count restarts from 0.
- Start pulse in the same cycle as the last accept: the start wins. That last write still issues, but done stays 0.
- Reset mid-LOAD: immediate return to IDLE with outputs 0. A pending write strobe is dropped.

## Structure
- Shared package holds the FSM state encoding, `CLOG2`-style width function (same semantics as `GETASIZE`), and `WWIDTH = CH_OUT*8`.
- One natural sub-module: `edge_detect` (2-flop rising-edge pulse). It is reused by the read-address controller's start logic.
- Multiplies stay inline as registered operators; DSP inference is acceptable.

## Test plan
- kx=3, ky=3, ciGroup=2, coAlign=64, continuous valid:
  - N=36; addresses 0..35 written in order, data matches the stimulus.
  - done rises the cycle after the 36th accept; ready is 0 afterwards.
- Same geometry, valid toggling 1-0-1 randomly:
  - exactly 36 writes, addresses contiguous, no duplicate or skipped words.
- kx=1, ky=1, ciGroup=1, coAlign=32:
  - N=1; one write at addr 0; done one cycle after the single accept.
- kx=3, ky=3, ciGroup=16, coAlign=128 with DEPTHWIDTH=9:
  - N=576 > 512; `O_cfg_err=1`, done=1, zero writes, ready never 1.
- Second `I_ap_start` edge after 10 of 36 words accepted:
  - at most one further write strobe; load restarts at addr 0; done only after 36 new accepts.
- `I_rst` pulled low during LOAD at word 20:
  - all outputs 0 asynchronously; after release the block stays IDLE until a new start edge.

Source files
------------

// File: rtl/weight_load_ctl_pkg.sv
// Shared types and helpers for the weight load path and its read-side sibling.
package weight_load_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC0 = 3'd1,
    ST_CALC1 = 3'd2,
    ST_LOAD  = 3'd3,
    ST_DONE  = 3'd4
  } wl_state_t;

  localparam int CH_OUT_DFLT = 32;
  localparam int WWIDTH_DFLT = CH_OUT_DFLT * 8;

  // Ceiling log2: bits needed to index n entries (getasize(1) == 0).
  function automatic int getasize(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/weight_load_ctl_edge_detect.sv
// Two-flop rising-edge detector; pulse is high for one cycle after the input is first seen high.
// Latency: pulse one cycle after the edge is sampled; no backpressure.
module weight_load_ctl_edge_detect (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_in,
  output logic O_pulse
);

  logic [1:0] s_start;

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) s_start <= '0;
    else        s_start <= {s_start[0], I_in};
  end

  assign O_pulse = s_start[0] & ~s_start[1];

endmodule

// File: rtl/weight_load_ctl.sv
// Streams one layer's weight words into the weight buffer at linear addresses 0..N-1, then raises done.
// Latency: LOAD three cycles after the start pulse, write one cycle after accept; ready drops only in non-LOAD states.
module weight_load_ctl
  import weight_load_ctl_pkg::*;
#(
  parameter int AXIWIDTH   = 32,
  parameter int DEPTHWIDTH = 9,
  parameter int CH_OUT     = CH_OUT_DFLT,
  parameter int WWIDTH     = CH_OUT * 8
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  input  logic                  I_ap_start,
  input  logic [AXIWIDTH-1:0]   I_kx_num,
  input  logic [AXIWIDTH-1:0]   I_ky_num,
  input  logic [DEPTHWIDTH-1:0] I_ciGroup,
  input  logic [DEPTHWIDTH:0]   I_coAlign,
  input  logic [WWIDTH-1:0]     I_wdata,
  input  logic                  I_wdata_valid,
  output logic                  O_wdata_ready,
  output logic                  O_wbuf_wr_en,
  output logic [DEPTHWIDTH-1:0] O_wbuf_waddr,
  output logic [WWIDTH-1:0]     O_wbuf_wdata,
  output logic                  O_weight_load_done,
  output logic                  O_cfg_err
);

  localparam int          CO_SHIFT = getasize(CH_OUT);
  localparam logic [32:0] CAP      = 33'(1) << DEPTHWIDTH;

  wl_state_t             state;
  logic                  start_pulse;
  logic                  accept;
  logic [31:0]           p0;
  logic [DEPTHWIDTH:0]   cw;
  logic [31:0]           n_words;
  logic [31:0]           n_calc;
  logic [DEPTHWIDTH:0]   wcnt;

  weight_load_ctl_edge_detect u_start_edge (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_in    (I_ap_start),
    .O_pulse (start_pulse)
  );

  assign accept = I_wdata_valid & O_wdata_ready;
  assign n_calc = p0 * 32'(I_ciGroup) * 32'(cw);

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      state              <= ST_IDLE;
      p0                 <= '0;
      cw                 <= '0;
      n_words            <= '0;
      wcnt               <= '0;
      O_wdata_ready      <= 1'b0;
      O_wbuf_wr_en       <= 1'b0;
      O_wbuf_waddr       <= '0;
      O_wbuf_wdata       <= '0;
      O_weight_load_done <= 1'b0;
      O_cfg_err          <= 1'b0;
    end else begin
      // The write port follows the handshake regardless of a concurrent restart.
      O_wbuf_wr_en <= accept;
      if (accept) begin
        O_wbuf_waddr <= wcnt[DEPTHWIDTH-1:0];
        O_wbuf_wdata <= I_wdata;
      end

      if (start_pulse) begin
        state              <= ST_CALC0;
        wcnt               <= '0;
        n_words            <= '0;
        O_wdata_ready      <= 1'b0;
        O_weight_load_done <= 1'b0;
        O_cfg_err          <= 1'b0;
      end else begin
        case (state)
          ST_CALC0: begin
            p0    <= 32'(I_kx_num * I_ky_num);
            cw    <= I_coAlign >> CO_SHIFT;
            state <= ST_CALC1;
          end
          ST_CALC1: begin
            n_words <= n_calc;
            if (n_calc == 32'd0 || {1'b0, n_calc} > CAP) begin
              state              <= ST_DONE;
              O_cfg_err          <= 1'b1;
              O_weight_load_done <= 1'b1;
            end else begin
              state         <= ST_LOAD;
              O_wdata_ready <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (accept) begin
              wcnt <= wcnt + 1'b1;
              if (32'(wcnt) == n_words - 32'd1) begin
                state              <= ST_DONE;
                O_wdata_ready      <= 1'b0;
                O_weight_load_done <= 1'b1;
              end
            end
          end
          ST_IDLE, ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_load_ctl.sv
// Randomized bench for weight_load_ctl: a word-level model of which words must land at which addresses.
module tb_weight_load_ctl;

  localparam int DW = 9;
  localparam int CH = 32;
  localparam int WW = CH * 8;
  localparam int CAPACITY = 1 << DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start;
  logic [31:0]   kx, ky;
  logic [DW-1:0] cig;
  logic [DW:0]   co;
  logic [WW-1:0] wdata;
  logic          wvld;
  logic          wrdy;
  logic          wr_en;
  logic [DW-1:0] waddr;
  logic [WW-1:0] wbdata;
  logic          done;
  logic          err;

  int n_chk  = 0;
  int n_fail = 0;
  int rdy_cnt = 0;

  logic [DW-1:0] wa_q[$];
  logic [WW-1:0] wd_q[$];
  logic [WW-1:0] exp_q[$];

  always #5 clk = ~clk;

  weight_load_ctl #(.AXIWIDTH(32), .DEPTHWIDTH(DW), .CH_OUT(CH), .WWIDTH(WW)) dut (
    .I_clk              (clk),
    .I_rst              (rst_n),
    .I_ap_start         (ap_start),
    .I_kx_num           (kx),
    .I_ky_num           (ky),
    .I_ciGroup          (cig),
    .I_coAlign          (co),
    .I_wdata            (wdata),
    .I_wdata_valid      (wvld),
    .O_wdata_ready      (wrdy),
    .O_wbuf_wr_en       (wr_en),
    .O_wbuf_waddr       (waddr),
    .O_wbuf_wdata       (wbdata),
    .O_weight_load_done (done),
    .O_cfg_err          (err)
  );

  // Buffer-side observer: records every write strobe and counts ready cycles.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wbdata);
    end
    if (wrdy) rdy_cnt++;
  end

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic start_layer(input int k_x, input int k_y, input int c_g, input int c_a);
    @(negedge clk);
    kx = k_x; ky = k_y; cig = DW'(c_g); co = (DW+1)'(c_a);
    ap_start = 1'b1;
    repeat (2) @(negedge clk);
    ap_start = 1'b0;
  endtask

  task automatic wait_ready();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (wrdy) ok = 1'b1;
    end
    chk("ready_up", 256'(ok), 256'(1));
  endtask

  // Offers words until `limit` are accepted; an offered word is held until taken.
  task automatic feed(input int limit, input int pct, output logic done_at_last);
    int acc, guard;
    logic hold;
    acc = 0; guard = 0; hold = 1'b0; done_at_last = 1'b0;
    while (acc < limit && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (!hold) begin
        wvld  = ($urandom_range(0, 99) < pct);
        wdata = rnd_word();
      end
      if (wvld && wrdy) begin
        exp_q.push_back(wdata);
        acc++;
        hold = 1'b0;
        done_at_last = done;
      end else begin
        hold = wvld;
      end
    end
    chk("feed_accepts", 256'(acc), 256'(limit));
  endtask

  task automatic check_writes(input int base, input int n);
    chk("write_count", 256'(wa_q.size() - base), 256'(n));
    for (int i = 0; i < n && base + i < wa_q.size() && i < exp_q.size(); i++) begin
      chk("write_addr", 256'(wa_q[base+i]), 256'(i));
      chk("write_data", wd_q[base+i], exp_q[i]);
    end
  endtask

  task automatic run_full(input int k_x, input int k_y, input int c_g, input int c_a, input int pct);
    int n, base;
    logic pre_done;
    n = k_x * k_y * c_g * (c_a / CH);
    base = wa_q.size();
    exp_q.delete();
    start_layer(k_x, k_y, c_g, c_a);
    wait_ready();
    feed(n, pct, pre_done);
    chk("done_before_last_write", 256'(pre_done), 256'(0));
    @(negedge clk);
    wvld = 1'b0;
    chk("done_after_last", 256'(done), 256'(1));
    chk("ready_after_last", 256'(wrdy), 256'(0));
    chk("last_wr_en", 256'(wr_en), 256'(1));
    chk("last_waddr", 256'(waddr), 256'(n - 1));
    repeat (3) @(negedge clk);
    chk("done_holds", 256'(done), 256'(1));
    chk("cfg_err_clear", 256'(err), 256'(0));
    check_writes(base, n);
  endtask

  task automatic run_bad(input int k_x, input int k_y, input int c_g, input int c_a);
    int base, r0;
    base = wa_q.size();
    r0 = rdy_cnt;
    start_layer(k_x, k_y, c_g, c_a);
    repeat (10) @(negedge clk);
    chk("cfg_err_set", 256'(err), 256'(1));
    chk("cfg_err_done", 256'(done), 256'(1));
    chk("cfg_err_no_writes", 256'(wa_q.size() - base), 256'(0));
    chk("cfg_err_no_ready", 256'(rdy_cnt - r0), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0, k_x, k_y, c_g, c_a, n;
    logic pre_done;
    rst_n = 1'b0; ap_start = 1'b0; wvld = 1'b0; wdata = '0;
    kx = '0; ky = '0; cig = '0; co = '0;
    #1;
    chk("rst_ready", 256'(wrdy), 256'(0));
    chk("rst_wr_en", 256'(wr_en), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Continuous, then bursty, then a single-word layer.
    run_full(3, 3, 2, 64, 100);
    run_full(3, 3, 2, 64, 55);
    run_full(1, 1, 1, 32, 100);

    // Over capacity (576 > 512) and an empty layer both flag a configuration error.
    run_bad(3, 3, 16, 128);
    run_bad(0, 3, 2, 64);

    for (int t = 0; t < 4; t++) begin
      k_x = $urandom_range(1, 3); k_y = $urandom_range(1, 3);
      c_g = $urandom_range(1, 4); c_a = CH * $urandom_range(1, 3);
      n = k_x * k_y * c_g * (c_a / CH);
      if (n <= CAPACITY) run_full(k_x, k_y, c_g, c_a, $urandom_range(30, 100));
    end

    // Restart after 10 accepted words: only the pending write completes, then a clean reload.
    base = wa_q.size();
    exp_q.delete();
    start_layer(3, 3, 2, 64);
    wait_ready();
    feed(10, 100, pre_done);
    @(negedge clk);
    wvld = 1'b0;
    ap_start = 1'b1;
    repeat (2) @(negedge clk);
    ap_start = 1'b0;
    @(negedge clk);
    chk("abort_done_low", 256'(done), 256'(0));
    check_writes(base, 10);
    base = wa_q.size();
    exp_q.delete();
    wait_ready();
    feed(36, 100, pre_done);
    chk("reload_done_before_last", 256'(pre_done), 256'(0));
    @(negedge clk);
    wvld = 1'b0;
    chk("reload_done", 256'(done), 256'(1));
    repeat (2) @(negedge clk);
    check_writes(base, 36);

    // Reset in the middle of a load.
    exp_q.delete();
    start_layer(3, 3, 2, 64);
    wait_ready();
    feed(20, 100, pre_done);
    @(negedge clk);
    wvld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 256'(wr_en), 256'(0));
    chk("arst_waddr", 256'(waddr), 256'(0));
    chk("arst_wdata", wbdata, 256'(0));
    chk("arst_ready", 256'(wrdy), 256'(0));
    chk("arst_done", 256'(done), 256'(0));
    chk("arst_err", 256'(err), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    base = wa_q.size();
    r0 = rdy_cnt;
    repeat (8) @(negedge clk);
    chk("idle_no_ready", 256'(rdy_cnt - r0), 256'(0));
    chk("idle_no_writes", 256'(wa_q.size() - base), 256'(0));
    chk("idle_done", 256'(done), 256'(0));
    run_full(2, 2, 1, 32, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
